// File: rtl/alu_seq_if.sv
// Control/status interface of the sequential accumulator ALU.
// The sequencer (master) issues op requests and controls the bus enable.
// The ALU (slave) returns the handshake and the flags.
interface alu_seq_if #(
  parameter int OP_W = 3
);
  logic            start;
  logic [OP_W-1:0] op;
  logic            ACC_bus;
  logic            busy;
  logic            done;
  logic            z_flag;
  logic            n_flag;
  logic            c_flag;

  modport master (
    output start, op, ACC_bus,
    input  busy, done, z_flag, n_flag, c_flag
  );

  modport slave (
    input  start, op, ACC_bus,
    output busy, done, z_flag, n_flag, c_flag
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential accumulator ALU: holds the accumulator, drives it onto the shared
// tri-state sysbus on request, and runs single-cycle ops (LOAD/ADD/SUB/AND/MOD2),
// multi-cycle logical shifts and an iterative shift-add multiply behind a
// start/busy/done handshake.
// The tri-state sysbus stays a plain inout port: it is a shared net with
// several drivers, not a point-to-point signal of the handshake.
module alu_seq #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) (
  input  logic              clock,
  input  logic              reset,
  alu_seq_if.slave          bus,
  inout  wire  [WORD_W-1:0] sysbus
);

  localparam int SH_W  = $clog2(WORD_W);
  localparam int CNT_W = $clog2(WORD_W + 1);

  localparam logic [OP_W-1:0] OP_LOAD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SHL  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SHR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_MOD2 = OP_W'(7);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [WORD_W-1:0]  acc;
  logic               c_reg;
  logic [CNT_W-1:0]   cnt;
  logic               shift_left;
  logic [WORD_W-1:0]  mcand;
  logic [WORD_W-1:0]  mplier;
  logic [WORD_W-1:0]  prod;

  logic [WORD_W-1:0]  opnd;
  logic [WORD_W-1:0]  prod_next;
  logic [WORD_W:0]    sum_ext;

  // Operand comes straight off the shared bus on the accepting edge.
  assign opnd      = sysbus;
  assign sum_ext   = {1'b0, acc} + {1'b0, opnd};
  assign prod_next = prod + (mplier[0] ? mcand : '0);

  // Accumulator is visible on the bus only when the sequencer enables it.
  assign sysbus = bus.ACC_bus ? acc : {WORD_W{1'bz}};

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.z_flag = (acc == '0);
  assign bus.n_flag = acc[WORD_W-1];
  assign bus.c_flag = c_reg;

  // Control FSM and datapath: op decode on accept, shift/multiply iteration.
  always_ff @(posedge clock) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would chain updates in order.
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      c_reg      <= 1'b0;
      cnt        <= '0;
      shift_left <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      prod       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state <= DONE;
            case (bus.op)
              OP_LOAD: begin
                acc   <= opnd;
                c_reg <= 1'b0;
              end
              OP_ADD: begin
                acc   <= sum_ext[WORD_W-1:0];
                c_reg <= sum_ext[WORD_W];
              end
              OP_SUB: begin
                acc   <= acc - opnd;
                c_reg <= (acc < opnd);
              end
              OP_AND: begin
                acc   <= acc & opnd;
                c_reg <= 1'b0;
              end
              OP_SHL, OP_SHR: begin
                cnt        <= CNT_W'(opnd[SH_W-1:0]);
                shift_left <= (bus.op == OP_SHL);
                // A zero count completes like a single-cycle op.
                if (opnd[SH_W-1:0] == '0) begin
                  c_reg <= 1'b0;
                end else begin
                  state <= SHIFT;
                end
              end
              OP_MUL: begin
                mcand  <= opnd;
                mplier <= acc;
                prod   <= '0;
                cnt    <= CNT_W'(WORD_W);
                state  <= MUL;
              end
              OP_MOD2: begin
                acc   <= {{(WORD_W-1){1'b0}}, acc[0]};
                c_reg <= 1'b0;
              end
              default: begin
                c_reg <= 1'b0;
              end
            endcase
          end
        end

        SHIFT: begin
          if (shift_left) begin
            c_reg <= acc[WORD_W-1];
            acc   <= {acc[WORD_W-2:0], 1'b0};
          end else begin
            c_reg <= acc[0];
            acc   <= {1'b0, acc[WORD_W-1:1]};
          end
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end

        MUL: begin
          prod   <= prod_next;
          mcand  <= {mcand[WORD_W-2:0], 1'b0};
          mplier <= {1'b0, mplier[WORD_W-1:1]};
          cnt    <= cnt - 1'b1;
          // acc keeps its old value until the last iteration lands.
          if (cnt == CNT_W'(1)) begin
            acc   <= prod_next;
            c_reg <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed ops with hand-computed results. The stimulus
// pushes the expected response into a scoreboard queue; a monitor pops and
// compares whenever done is seen.
module tb_alu_seq;

  localparam int WORD_W = 8;
  localparam int OP_W   = 3;

  localparam logic [2:0] LOAD = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3,
                         SHL  = 3'd4, SHR = 3'd5, MUL = 3'd6, MOD2 = 3'd7;

  typedef struct {
    string       name;
    logic [7:0]  acc;
    logic        c;
    logic        z;
    logic        n;
    int          lat;
    int          accept_cyc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        tb_en;
  logic [7:0]  tb_val;
  wire  [7:0]  sysbus;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit prev_done = 1'b0;
  exp_t sb[$];

  alu_seq_if #(.OP_W(OP_W)) bus ();

  alu_seq #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .sysbus (sysbus)
  );

  // The bench's own driver on the shared bus.
  assign sysbus = tb_en ? tb_val : 8'bz;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
  endtask

  // Monitor: compares the DUT response against the oldest expectation.
  always @(negedge clock) begin
    if (!reset && bus.done) begin
      check("done_single_cycle", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_acc"}, 32'(dut.acc), 32'(e.acc));
        check({e.name, "_c"},   32'(bus.c_flag), 32'(e.c));
        check({e.name, "_z"},   32'(bus.z_flag), 32'(e.z));
        check({e.name, "_n"},   32'(bus.n_flag), 32'(e.n));
        check({e.name, "_lat"}, 32'(cyc - e.accept_cyc), 32'(e.lat));
      end
    end
    prev_done = bus.done;
  end

  // Present one op for exactly one rising edge; call at a negedge while idle.
  task automatic issue(input logic [2:0] o, input logic [7:0] opnd,
                       input logic [7:0] e_acc, input logic e_c, input logic e_z,
                       input logic e_n, input int lat, input string name);
    exp_t e;
    e.name = name; e.acc = e_acc; e.c = e_c; e.z = e_z; e.n = e_n;
    e.lat = lat; e.accept_cyc = cyc;
    sb.push_back(e);
    bus.ACC_bus = 1'b0;
    tb_en       = 1'b1;
    tb_val      = opnd;
    bus.op      = o;
    bus.start   = 1'b1;
    @(posedge clock);
  endtask

  // Wait (bounded) until idle, counting busy cycles; optionally poke start
  // while busy, including in the DONE cycle.
  task automatic wait_idle(input bit poke, output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      bus.start = 1'b0;
      tb_en     = 1'b0;
      if (!bus.busy) break;
      busy_cycles++;
      if (poke && (busy_cycles == 3 || busy_cycles == 9)) begin
        bus.start = 1'b1;
        bus.op    = LOAD;
        tb_en     = 1'b1;
        tb_val    = 8'h55;
      end
    end
    check("reached_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic run(input logic [2:0] o, input logic [7:0] opnd,
                     input logic [7:0] e_acc, input logic e_c, input logic e_z,
                     input logic e_n, input int lat, input string name);
    int bc;
    issue(o, opnd, e_acc, e_c, e_z, e_n, lat, name);
    wait_idle(1'b0, bc);
  endtask

  initial begin
    int bc;
    reset = 1'b1; bus.start = 1'b0; bus.op = '0; bus.ACC_bus = 1'b0;
    tb_en = 1'b0; tb_val = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state
    bus.ACC_bus = 1'b1;
    #1;
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_z",      32'(bus.z_flag), 32'd1);
    check("rst_n",      32'(bus.n_flag), 32'd0);
    check("rst_c",      32'(bus.c_flag), 32'd0);
    check("rst_sysbus", 32'(sysbus),     32'h00);
    @(negedge clock);

    // 1: LOAD
    run(LOAD, 8'h3C, 8'h3C, 0, 0, 0, 1, "load_3c");

    // 6: bus release / drive
    bus.ACC_bus = 1'b1; tb_en = 1'b0;
    #1 check("bus_drives_acc", 32'(sysbus), 32'h3C);
    bus.ACC_bus = 1'b0; tb_en = 1'b1; tb_val = 8'hA5;
    #1 check("bus_released", 32'(sysbus), 32'hA5);
    tb_en = 1'b0;
    @(negedge clock);

    // 2: ADD with carry, SUB with borrow, AND clears carry
    run(LOAD, 8'hF0, 8'hF0, 0, 0, 1, 1, "load_f0");
    run(ADD,  8'h20, 8'h10, 1, 0, 0, 1, "add_20");
    run(SUB,  8'h11, 8'hFF, 1, 0, 1, 1, "sub_11");
    run(LOAD, 8'h10, 8'h10, 0, 0, 0, 1, "load_10");
    run(AND_, 8'h3C, 8'h10, 0, 0, 0, 1, "and_3c");

    // 3: shifts
    run(LOAD, 8'h81, 8'h81, 0, 0, 1, 1, "load_81");
    issue(SHL, 8'h03, 8'h08, 0, 0, 0, 4, "shl_3");
    wait_idle(1'b0, bc);
    check("shl_3_busy_cycles", 32'(bc), 32'd4);
    run(SHR,  8'h00, 8'h08, 0, 0, 0, 1, "shr_0");
    run(LOAD, 8'h03, 8'h03, 0, 0, 0, 1, "load_03");
    run(SHR,  8'h01, 8'h01, 1, 0, 0, 2, "shr_1");

    // 4: multiply
    run(LOAD, 8'd13, 8'd13, 0, 0, 0, 1, "load_13");
    issue(MUL, 8'd11, 8'h8F, 0, 0, 1, 9, "mul_13x11");
    wait_idle(1'b0, bc);
    check("mul_busy_cycles", 32'(bc), 32'd9);
    run(LOAD, 8'h10, 8'h10, 0, 0, 0, 1, "load_10b");
    run(MUL,  8'h10, 8'h00, 0, 1, 0, 9, "mul_wrap");

    // 5: start while busy (mid-MUL and in DONE) is ignored
    run(LOAD, 8'd13, 8'd13, 0, 0, 0, 1, "load_13b");
    issue(MUL, 8'd11, 8'h8F, 0, 0, 1, 9, "mul_poked");
    wait_idle(1'b1, bc);
    check("mul_poked_busy_cycles", 32'(bc), 32'd9);
    @(negedge clock);
    check("poke_not_queued_busy", 32'(bus.busy), 32'd0);
    check("poke_not_queued_acc",  32'(dut.acc),  32'h8F);

    // 5: reset in cycle 3 of MUL aborts without done
    run(LOAD, 8'd13, 8'd13, 0, 0, 0, 1, "load_13c");
    bus.ACC_bus = 1'b0; tb_en = 1'b1; tb_val = 8'd11;
    bus.op = MUL; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0; tb_en = 1'b0;
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus.ACC_bus = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy),   32'd0);
    check("abort_done", 32'(bus.done),   32'd0);
    check("abort_z",    32'(bus.z_flag), 32'd1);
    check("abort_c",    32'(bus.c_flag), 32'd0);
    check("abort_bus",  32'(sysbus),     32'h00);
    bus.ACC_bus = 1'b0;
    repeat (12) @(negedge clock);

    // 6: MOD2
    run(LOAD, 8'd1, 8'd1, 0, 0, 0, 1, "load_1");
    run(MOD2, 8'h00, 8'd1, 0, 0, 0, 1, "mod2_1");
    run(LOAD, 8'd6, 8'd6, 0, 0, 0, 1, "load_6");
    run(MOD2, 8'h00, 8'd0, 0, 1, 0, 1, "mod2_6");

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
